// File: rtl/softmax_max_sub_if.sv
// Stream bundle for softmax_max_sub: input vector stream, output difference stream, truncation flag.
// The master side drives input elements and output backpressure; the slave side is the block itself.
interface softmax_max_sub_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          trunc;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, trunc
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, trunc
    );
endinterface

// File: rtl/softmax_max_sub.sv
// Softmax front end: buffers one Q.8 vector, tracks its maximum, then streams element - max (all <= 0).
// Define MAXSUB_SAT_EN to clamp extreme-range differences to the most negative value instead of wrapping.
//
// state | meaning
// LOAD  | accepting elements into the buffer, tracking the running maximum
// EMIT  | streaming buffered element minus maximum, inputs stalled
module softmax_max_sub #(
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    softmax_max_sub_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        wr_idx_q, wr_idx_d;
    logic [AW-1:0]        rd_idx_q, rd_idx_d;
    logic [AW-1:0]        last_idx_q, last_idx_d;
    logic signed [DW-1:0] max_q, max_d;
    logic                 have_first_q, have_first_d;
    logic                 trunc_q, trunc_d;
    logic signed [DW-1:0] mem_q [DEPTH];

    logic                 in_acc;
    logic                 out_hs;
    logic signed [DW-1:0] rd_elem;
    logic signed [DW-1:0] diff_red;

    assign in_acc  = bus.in_valid && (state_q == LOAD);
    assign out_hs  = bus.out_ready && (state_q == EMIT);
    assign rd_elem = mem_q[rd_idx_q];

`ifdef MAXSUB_SAT_EN
    logic [DW:0] diff;

    // The element never exceeds the max, so only the negative side can leave the DW range.
    always_comb begin
        diff = {rd_elem[DW-1], rd_elem} - {max_q[DW-1], max_q};
        if (diff[DW] && !diff[DW-1]) begin
            diff_red = {1'b1, {(DW-1){1'b0}}};
        end else begin
            diff_red = diff[DW-1:0];
        end
    end
`else
    // Modular DW-bit subtraction equals the low DW bits of the widened difference.
    assign diff_red = rd_elem - max_q;
`endif

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        last_idx_d   = last_idx_q;
        max_d        = max_q;
        have_first_d = have_first_q;
        trunc_d      = trunc_q;
        case (state_q)
            LOAD: begin
                if (in_acc) begin
                    wr_idx_d     = wr_idx_q + 1'b1;
                    have_first_d = 1'b1;
                    if (!have_first_q) begin
                        max_d   = bus.in_data;
                        trunc_d = 1'b0;
                    end else if ($signed(bus.in_data) > max_q) begin
                        max_d = bus.in_data;
                    end
                    // A full buffer closes the vector even without in_last.
                    if (bus.in_last || (wr_idx_q == AW'(DEPTH - 1))) begin
                        state_d    = EMIT;
                        last_idx_d = wr_idx_q;
                        trunc_d    = !bus.in_last;
                    end
                end
            end
            EMIT: begin
                if (out_hs) begin
                    if (rd_idx_q == last_idx_q) begin
                        state_d      = LOAD;
                        wr_idx_d     = '0;
                        rd_idx_d     = '0;
                        have_first_d = 1'b0;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            last_idx_q   <= '0;
            max_q        <= '0;
            have_first_q <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            last_idx_q   <= last_idx_d;
            max_q        <= max_d;
            have_first_q <= have_first_d;
            trunc_q      <= trunc_d;
        end
    end

    // Buffer contents need no reset; the indices alone decide what is valid.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            mem_q[wr_idx_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_last  = (state_q == EMIT) && (rd_idx_q == last_idx_q);
    assign bus.out_data  = (state_q == EMIT) ? diff_red : '0;
    assign bus.trunc     = trunc_q;
endmodule

// File: tb/tb_softmax_max_sub.sv
// Self-checking bench for softmax_max_sub: expected differences are queued on load and popped on each output handshake.
// Honours MAXSUB_SAT_EN in its reference model when the macro is defined for the build.
module tb_softmax_max_sub;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic signed [DW-1:0] vec[$];
    exp_t                 exp_q[$];

    softmax_max_sub_if #(.DW(DW)) bus ();

    softmax_max_sub #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Drives vec[0..n-1]; pushes the expected output stream for the accepted part of the vector.
    task automatic load_vec(input int n, input bit with_last);
        logic signed [DW-1:0] mx;
        longint               d;
        exp_t                 e;
        int                   cnt;
        int                   budget;
        cnt = 0;
        mx  = '0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vec[i];
            bus.in_last  = with_last && (i == n - 1);
            budget = 0;
            while (bus.in_ready !== 1'b1 && budget < 200) begin
                @(posedge clk); #1;
                budget++;
            end
            if (budget >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL load_timeout: in_ready=%b, required 1 within 200 cycles", bus.in_ready);
            end
            @(posedge clk); #1;
            if (cnt == 0 || vec[i] > mx) mx = vec[i];
            cnt++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            d = longint'(vec[i]) - longint'(mx);
`ifdef MAXSUB_SAT_EN
            if (d < -(longint'(1) <<< (DW - 1))) d = -(longint'(1) <<< (DW - 1));
`endif
            e.data = d[DW-1:0];
            e.last = (i == cnt - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.out_data !== '0 || bus.trunc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_last=%b out_data=%h trunc=%b, required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.trunc);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   got;
        int   cyc;
        vec = '{32'sd256, 32'sd512, -32'sd128, 32'sd512};
        load_vec(4, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: out_valid=%b in_ready=%b after last accept, required 1 0", bus.out_valid, bus.in_ready);
        end
        got = 0; cyc = 0;
        while (got < 4 && cyc < 50) begin
            bus.out_ready = 1'b1;
            if (bus.out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.out_data !== e.data || bus.out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL basic_out[%0d]: got %0d last=%b, required %0d last=%b",
                             got, $signed(bus.out_data), bus.out_last, $signed(e.data), e.last);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d outputs, required 4", got);
        end
    endtask

    task automatic test_single();
        exp_t e;
        vec = '{-32'sd300};
        load_vec(1, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.out_data !== e.data) begin
            n_fail++;
            $display("FAIL single_out: valid=%b last=%b data=%0d, required 1 1 %0d",
                     bus.out_valid, bus.out_last, $signed(bus.out_data), $signed(e.data));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_return: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   got;
        int   cyc;
        bit   rp[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vec = '{32'sd0, -32'sd256, 32'sd100};
        load_vec(3, 1'b1);
        got = 0; cyc = 0;
        while (got < 3 && cyc < 50) begin
            bus.out_ready = (cyc < 5) ? rp[cyc] : 1'b1;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
                n_checks++;
                if (bus.out_data !== exp_q[0].data || bus.out_last !== exp_q[0].last) begin
                    n_fail++;
                    $display("FAIL bp_hold[%0d]: got %0d last=%b, required %0d last=%b",
                             cyc, $signed(bus.out_data), bus.out_last, $signed(exp_q[0].data), exp_q[0].last);
                end
            end else if (bus.out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.out_data !== e.data || bus.out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL bp_out[%0d]: got %0d last=%b, required %0d last=%b",
                             got, $signed(bus.out_data), bus.out_last, $signed(e.data), e.last);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (got != 3 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d outputs out_valid=%b, required 3 outputs and 0", got, bus.out_valid);
        end
    endtask

    task automatic test_overflow();
        exp_t                 e;
        int                   got;
        int                   cyc;
        logic signed [DW-1:0] all[$];
        all = '{};
        for (int i = 0; i < DEPTH + 2; i++) all.push_back(DW'((i * 37) % 500 - 250));
        vec = all;
        load_vec(DEPTH, 1'b0);
        n_checks++;
        if (bus.trunc !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_trunc: trunc=%b out_valid=%b, required 1 1", bus.trunc, bus.out_valid);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = all[DEPTH];
        bus.in_last  = 1'b0;
        got = 0; cyc = 0;
        while (got < DEPTH && cyc < 4 * DEPTH) begin
            bus.out_ready = 1'b1;
            if (bus.out_valid === 1'b1) begin
                n_checks++;
                if (bus.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_in_ready[%0d]: got %b during EMIT, required 0", got, bus.in_ready);
                end
                e = exp_q.pop_front();
                n_checks++;
                if (bus.out_data !== e.data || bus.out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL ovf_out[%0d]: got %0d last=%b, required %0d last=%b",
                             got, $signed(bus.out_data), bus.out_last, $signed(e.data), e.last);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (got != DEPTH || bus.trunc !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d outputs trunc=%b, required %0d and trunc 1 before next accept", got, bus.trunc, DEPTH);
        end
        vec = '{all[DEPTH], all[DEPTH+1]};
        load_vec(2, 1'b1);
        n_checks++;
        if (bus.trunc !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_trunc_clear: trunc=%b, required 0", bus.trunc);
        end
        got = 0; cyc = 0;
        while (got < 2 && cyc < 20) begin
            bus.out_ready = 1'b1;
            if (bus.out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.out_data !== e.data || bus.out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL ovf_next_out[%0d]: got %0d last=%b, required %0d last=%b",
                             got, $signed(bus.out_data), bus.out_last, $signed(e.data), e.last);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL ovf_next_count: got %0d outputs, required 2", got);
        end
    endtask

    task automatic test_extremes();
        exp_t e;
        int   got;
        int   cyc;
        vec = '{32'sh7FFF_FFFF, 32'sh8000_0000};
        load_vec(2, 1'b1);
        got = 0; cyc = 0;
        while (got < 2 && cyc < 20) begin
            bus.out_ready = 1'b1;
            if (bus.out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.out_data !== e.data || bus.out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL extreme_out[%0d]: got %h last=%b, required %h last=%b",
                             got, bus.out_data, bus.out_last, e.data, e.last);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL extreme_count: got %0d outputs, required 2", got);
        end
    endtask

    task automatic test_reset_mid_emit();
        exp_t e;
        vec = '{32'sd10, 32'sd20, 32'sd30};
        load_vec(3, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e.data) begin
            n_fail++;
            $display("FAIL rstmid_first: valid=%b data=%0d, required 1 %0d", bus.out_valid, $signed(bus.out_data), $signed(e.data));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.trunc !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_state: out_valid=%b in_ready=%b trunc=%b, required 0 1 0", bus.out_valid, bus.in_ready, bus.trunc);
        end
        vec = '{32'sd5};
        load_vec(1, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.out_data !== e.data) begin
            n_fail++;
            $display("FAIL rstmid_next: valid=%b last=%b data=%0d, required 1 1 %0d",
                     bus.out_valid, bus.out_last, $signed(bus.out_data), $signed(e.data));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_backpressure();
        test_overflow();
        test_extremes();
        test_reset_mid_emit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/softmax_max_sub.md
# softmax_max_sub

Upstream stage of the softmax datapath. Buffers one input vector of signed fixed-point scores (8 fractional bits, scale 256) and finds its maximum. It then streams each element minus that maximum, so every output is ≤ 0. This feeds the exponent stage, which expects non-positive arguments so that exp(q) ≤ 1.0 and never overflows.

## Interface
- `DW`, 32: data width, signed two's complement, Q.8 fixed point.
- `DEPTH`, 64: maximum vector length held in the buffer; must be a power of two ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: input element valid.
- `in_ready`  out  1: block accepts input (LOAD state).
- `in_data`  in  DW: signed input score.
- `in_last`  in  1: marks the final element of the vector.
- `out_valid`  out  1: output element valid.
- `out_ready`  in  1: downstream accepts output.
- `out_data`  out  DW: signed `in_data[i] − max`, always ≤ 0.
- `out_last`  out  1: marks the final output element of the vector.
- `trunc`  out  1: the current or most recent vector exceeded DEPTH and was truncated.

## Operation
- States: LOAD and EMIT. Reset enters LOAD.
- **LOAD**
  - `in_ready`=1. On each accept (`in_valid & in_ready`), write `in_data` to `buf[wr_idx]` and increment `wr_idx`.
  - The first element of a vector loads `max` directly. Later elements update `max` when `in_data > max` (signed compare).
  - Accepting `in_last`=1 moves the state to EMIT and latches `len = wr_idx + 1`.
  - Accepting the DEPTH-th element with `in_last`=0 counts as last: go to EMIT with `len = DEPTH` and set `trunc`=1. Inputs stall (`in_ready`=0) until EMIT completes.
  - The first accept of a new vector clears `trunc`.
- **EMIT**
  - `in_ready`=0 and `out_valid`=1.
  - `out_data = buf[rd_idx] − max`.
  - `out_last = (rd_idx == len−1)`.
  - On each handshake (`out_valid & out_ready`), increment `rd_idx`.
  - The handshake with `out_last`=1 returns the state to LOAD and resets `wr_idx`, `rd_idx` and the first-element flag to 0.
- **Arithmetic**
  - The subtraction is computed at DW+1 bits, then reduced to DW (see Configuration).
  - The maximum element of the vector always produces exactly 0.
  - Equal elements are valid; ties need no special handling.
- **Output stability:** `out_data`, `out_valid` and `out_last` are driven only from registered state, with no combinational path from any input. They hold stable while `out_valid & !out_ready`.
- **Reset mid-operation:** synchronous reset in either state discards the buffered vector and returns to LOAD with all indices 0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `trunc`=0, state LOAD, `max`=0, `wr_idx`=`rd_idx`=0.
- Load throughput: one element per cycle.
- `out_valid` rises the cycle after the last input is accepted, so a one-element vector has 1-cycle latency.
- Emit throughput: one element per cycle while `out_ready`=1.
- `out_ready` low stalls the output with no loss of data.
- No overlap between vectors: the first input of vector k+1 is accepted no earlier than the cycle after the `out_last` handshake of vector k.
- Per-vector occupancy: `len` load cycles plus `len` emit cycles, plus stall cycles.

## Configuration
- `MAXSUB_SAT_EN` defined: a (DW+1)-bit difference below −2^(DW−1) saturates to −2^(DW−1). This occurs for inputs near the opposite extremes of the range. The output therefore never wraps positive.
- Without the macro: the difference is truncated to DW bits, which wraps in the extreme-range case. In-range Q.8 scores are unaffected. The saturation logic is omitted.

## Test plan
- Vector [256, 512, −128, 512] with last on element 4, `out_ready`=1 → outputs [−256, 0, −640, 0]; `out_last` on 4th; `out_valid` first high 1 cycle after the last accept.
- Single element [−300] with `in_last`=1 → out [0] with `out_last`=1 in the next cycle; state back to LOAD.
- Backpressure: vector [0, −256, 100], `out_ready` toggled 1,0,0,1,1 → `out_data` holds across stalls; sequence [−100, −356, 0] delivered exactly once each.
- Overflow: DEPTH+2 elements, no `in_last` → `trunc`=1; DEPTH outputs with `out_last` on the DEPTH-th; `in_ready`=0 during EMIT; `trunc` clears on the next vector's first accept.
- Extremes: [0x7FFFFFFF, 0x80000000] → with `MAXSUB_SAT_EN`: [0, 0x80000000]; without: [0, 0x00000001] (wrap).
- Reset asserted for one cycle mid-EMIT of [10, 20, 30] after one output → `out_valid`=0, `in_ready`=1 next cycle; a following vector [5] outputs [0].
